// File: rtl/axis_arbiter.sv
// axis_arbiter
//   Packet-aware round-robin arbiter sharing one AXI-stream style output
//   channel between NUM input streams. The granted input's beats pass through
//   one registered output stage, and each beat is tagged with its source index.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | no grant held; arbitrate ivalid starting from the rr pointer
//   GRANT  | input 'grant' owns the output until its releasing beat is taken
//
// Ports:
//   clock, resetn        rising-edge clock, asynchronous active-low reset
//   idata/ilast/ivalid   NUM packed input streams (stream i at [i*WIDTH +: WIDTH])
//   iready               per-input ready, combinational, at most one bit high
//   odata/olast/ochan    registered output beat, end-of-packet flag, source index
//   ovalid/oready        output handshake
//   busy                 high while a grant is held
module axis_arbiter #(
    parameter int WIDTH  = 8,
    parameter int NUM    = 4,
    parameter int CHAN   = 2,
    parameter int PACKET = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NUM*WIDTH-1:0] idata,
    input  logic [NUM-1:0]       ilast,
    input  logic [NUM-1:0]       ivalid,
    output logic [NUM-1:0]       iready,
    output logic [WIDTH-1:0]     odata,
    output logic                 olast,
    output logic [CHAN-1:0]      ochan,
    output logic                 ovalid,
    input  logic                 oready,
    output logic                 busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]       state;
    logic [CHAN-1:0]  grant;
    logic [CHAN-1:0]  ptr;
    logic [CHAN-1:0]  pick;
    logic             found;
    logic             load_ok;
    logic             xfer;
    logic             beat_last;
    logic             release_g;
    logic [WIDTH-1:0] gdata;
    logic             glast;
    logic             gvalid;

    // First requesting input at or after ptr, wrapping modulo NUM.
    always_comb begin
        int j;
        pick  = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM) begin
                j = j - NUM;
            end
            if (!found && ivalid[j]) begin
                pick  = CHAN'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        gdata  = '0;
        glast  = 1'b0;
        gvalid = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (grant == CHAN'(i)) begin
                gdata  = idata[i*WIDTH +: WIDTH];
                glast  = ilast[i];
                gvalid = ivalid[i];
            end
        end
    end

    assign busy    = (state == S_GRANT);
    assign load_ok = !ovalid || oready;

    always_comb begin
        iready = '0;
        for (int i = 0; i < NUM; i++) begin
            iready[i] = busy && load_ok && (grant == CHAN'(i));
        end
    end

    assign xfer      = busy && load_ok && gvalid;
    assign beat_last = (PACKET == 0) ? 1'b1 : glast;
    assign release_g = xfer && beat_last;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        state <= S_GRANT;
                        grant <= pick;
                    end
                end
                default: begin
                    if (release_g) begin
                        state <= S_IDLE;
                        // wrap at NUM, not at 2**CHAN
                        ptr   <= (grant == CHAN'(NUM - 1)) ? '0 : grant + CHAN'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovalid <= 1'b0;
            olast  <= 1'b0;
            ochan  <= '0;
        end else if (xfer) begin
            ovalid <= 1'b1;
            olast  <= beat_last;
            ochan  <= grant;
        end else if (oready) begin
            ovalid <= 1'b0;
        end
    end

    // Data path carries no reset; ovalid qualifies it.
    always_ff @(posedge clock) begin
        if (xfer) begin
            odata <= gdata;
        end
    end

endmodule

// File: tb/tb_axis_arbiter.sv
module tb_axis_arbiter;

    localparam int NUM = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] idata = '0;
    logic [3:0]  ilast = '0;
    logic [3:0]  ivalid = '0;
    logic        oready = 1'b1;

    logic [3:0]  a_iready, b_iready;
    logic [7:0]  a_odata, b_odata;
    logic        a_olast, b_olast, a_ovalid, b_ovalid, a_busy, b_busy;
    logic [1:0]  a_ochan, b_ochan;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    axis_arbiter #(.WIDTH(8), .NUM(4), .CHAN(2), .PACKET(1)) u_a (
        .clock(clock), .resetn(resetn), .idata(idata), .ilast(ilast),
        .ivalid(ivalid), .iready(a_iready), .odata(a_odata), .olast(a_olast),
        .ochan(a_ochan), .ovalid(a_ovalid), .oready(oready), .busy(a_busy));

    axis_arbiter #(.WIDTH(8), .NUM(4), .CHAN(2), .PACKET(0)) u_b (
        .clock(clock), .resetn(resetn), .idata(idata), .ilast(ilast),
        .ivalid(ivalid), .iready(b_iready), .odata(b_odata), .olast(b_olast),
        .ochan(b_ochan), .ovalid(b_ovalid), .oready(oready), .busy(b_busy));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: owner index (-1 = none), rr start point, one pending output beat.
    int         own[2];
    int         rr[2];
    bit         pv[2];
    logic [7:0] pd[2];
    int         pc[2];
    bit         pl[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            own[m] = -1; rr[m] = 0; pv[m] = 0; pd[m] = '0; pc[m] = 0; pl[m] = 0;
        end
    endtask

    task automatic model_check(input int m, input logic [3:0] ir, input logic bz,
                               input logic ov, input logic [7:0] od,
                               input logic [1:0] oc, input logic ol);
        logic [3:0] exp_ir;
        exp_ir = '0;
        if (own[m] >= 0 && (!pv[m] || oready)) exp_ir[own[m]] = 1'b1;
        chk("rnd_iready", 32'(ir), 32'(exp_ir));
        chk("rnd_busy", 32'(bz), 32'(own[m] >= 0));
        chk("rnd_ovalid", 32'(ov), 32'(pv[m]));
        if (pv[m]) begin
            chk("rnd_odata", 32'(od), 32'(pd[m]));
            chk("rnd_ochan", 32'(oc), 32'(pc[m]));
            chk("rnd_olast", 32'(ol), 32'(pl[m]));
        end
    endtask

    task automatic model_step(input int m);
        int o;
        bit x;
        bit done;
        o = own[m];
        x = (o >= 0) && (!pv[m] || oready) && ivalid[o];
        if (pv[m] && oready) pv[m] = 0;
        if (x) begin
            pv[m] = 1;
            pd[m] = idata[o*8 +: 8];
            pc[m] = o;
            pl[m] = (m == 1) ? 1'b1 : ilast[o];
            if (m == 1 || ilast[o]) begin
                rr[m]  = (o + 1) % NUM;
                own[m] = -1;
            end
        end else if (o < 0) begin
            done = 0;
            for (int k = 0; k < NUM; k++) begin
                if (!done && ivalid[(rr[m] + k) % NUM]) begin
                    own[m] = (rr[m] + k) % NUM;
                    done = 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        ivalid = '0; ilast = '0; idata = '0; oready = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  iv;
        logic [31:0] id;
        logic [3:0]  il;
        logic        ordy;
        logic [3:0]  e_ir;
        logic        e_bz;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_oc;
        logic        e_ol;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic [3:0] iv, logic [31:0] id, logic [3:0] il,
                                logic [3:0] ir, logic bz, logic ov, logic [7:0] od,
                                logic [1:0] oc, logic ol);
        vec_t v;
        v.iv = iv; v.id = id; v.il = il; v.ordy = 1'b1;
        v.e_ir = ir; v.e_bz = bz; v.e_ov = ov; v.e_od = od; v.e_oc = oc; v.e_ol = ol;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  bv[3];
        logic [7:0]  got[$];
        logic [10:0] gotb[$];
        logic [10:0] expb[4];
        logic [7:0]  s_od;
        logic [1:0]  s_oc;
        logic        s_ol, s_ov, hs, hs0, hs1;
        int          k, k0, k1;

        // single beat from input 0, then 3-beat packet from input 2 with input 1 waiting
        tbl[0]  = mk(4'b0001, 32'h0000_00A5, 4'b0001, 4'b0000, 0, 0, 8'h00, 2'd0, 0);
        tbl[1]  = mk(4'b0001, 32'h0000_00A5, 4'b0001, 4'b0001, 1, 0, 8'h00, 2'd0, 0);
        tbl[2]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 1, 8'hA5, 2'd0, 1);
        tbl[3]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 0, 8'h00, 2'd0, 0);
        tbl[4]  = mk(4'b0100, 32'h0011_0000, 4'b0000, 4'b0000, 0, 0, 8'h00, 2'd0, 0);
        tbl[5]  = mk(4'b0110, 32'h0011_7700, 4'b0010, 4'b0100, 1, 0, 8'h00, 2'd0, 0);
        tbl[6]  = mk(4'b0110, 32'h0022_7700, 4'b0010, 4'b0100, 1, 1, 8'h11, 2'd2, 0);
        tbl[7]  = mk(4'b0110, 32'h0033_7700, 4'b0110, 4'b0100, 1, 1, 8'h22, 2'd2, 0);
        tbl[8]  = mk(4'b0010, 32'h0000_7700, 4'b0010, 4'b0000, 0, 1, 8'h33, 2'd2, 1);
        tbl[9]  = mk(4'b0010, 32'h0000_7700, 4'b0010, 4'b0010, 1, 0, 8'h00, 2'd0, 0);
        tbl[10] = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 1, 8'h77, 2'd1, 1);
        tbl[11] = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 0, 8'h00, 2'd0, 0);

        do_reset();
        chk("rst_ovalid", 32'(a_ovalid), 32'd0);
        chk("rst_olast", 32'(a_olast), 32'd0);
        chk("rst_ochan", 32'(a_ochan), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_iready", 32'(a_iready), 32'd0);

        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            ivalid = tbl[i].iv; idata = tbl[i].id; ilast = tbl[i].il; oready = tbl[i].ordy;
            @(negedge clock);
            chk($sformatf("tbl%0d_iready", i), 32'(a_iready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_busy", i), 32'(a_busy), 32'(tbl[i].e_bz));
            chk($sformatf("tbl%0d_ovalid", i), 32'(a_ovalid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_odata", i), 32'(a_odata), 32'(tbl[i].e_od));
                chk($sformatf("tbl%0d_ochan", i), 32'(a_ochan), 32'(tbl[i].e_oc));
                chk($sformatf("tbl%0d_olast", i), 32'(a_olast), 32'(tbl[i].e_ol));
            end
        end

        // all inputs valid, single-beat packets: rotation 0,1,2,3,0 at one beat per 2 cycles
        do_reset();
        ivalid = 4'b1111; ilast = 4'b1111; idata = 32'h4342_4140;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            chk($sformatf("rr_ovalid_c%0d", c), 32'(a_ovalid), 32'(c % 2 == 0));
            if (c % 2 == 0) begin
                chk($sformatf("rr_ochan_c%0d", c), 32'(a_ochan), 32'((c / 2 - 1) % 4));
                chk($sformatf("rr_odata_c%0d", c), 32'(a_odata), 32'(8'h40 + (c / 2 - 1) % 4));
            end
        end

        // output stall for 3 cycles mid-packet
        do_reset();
        bv[0] = 8'h10; bv[1] = 8'h20; bv[2] = 8'h30;
        k = 0; hs = 0;
        s_od = '0; s_oc = '0; s_ol = 0; s_ov = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clock); #1;
            if (hs) k++;
            ivalid = {3'b000, k < 3};
            idata  = {24'h0, (k < 3) ? bv[k] : 8'h00};
            ilast  = {3'b000, k == 2};
            oready = !(c >= 3 && c <= 5);
            @(negedge clock);
            if (c >= 3 && c <= 5) begin
                chk($sformatf("stall_ovalid_c%0d", c), 32'(a_ovalid), 32'd1);
                chk($sformatf("stall_iready_c%0d", c), 32'(a_iready), 32'd0);
            end
            if (c >= 4 && c <= 5) begin
                chk($sformatf("stall_odata_c%0d", c), 32'(a_odata), 32'(s_od));
                chk($sformatf("stall_ochan_c%0d", c), 32'(a_ochan), 32'(s_oc));
                chk($sformatf("stall_olast_c%0d", c), 32'(a_olast), 32'(s_ol));
            end
            s_od = a_odata; s_oc = a_ochan; s_ol = a_olast; s_ov = a_ovalid;
            hs = a_iready[0] && ivalid[0];
            if (a_ovalid && oready) got.push_back(a_odata);
        end
        chk("stall_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) chk($sformatf("stall_beat%0d", i), 32'(got[i]), 32'(bv[i]));
        end

        // non-packet instance: grant released each beat, olast forced high
        do_reset();
        k0 = 0; k1 = 0; hs0 = 0; hs1 = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clock); #1;
            if (hs0) k0++;
            if (hs1) k1++;
            ivalid = {2'b00, k1 < 2, k0 < 2};
            idata  = {16'h0, 8'(8'hB0 + k1), 8'(8'hA0 + k0)};
            ilast  = 4'b0000;
            oready = 1'b1;
            @(negedge clock);
            hs0 = b_iready[0] && ivalid[0];
            hs1 = b_iready[1] && ivalid[1];
            if (b_ovalid && oready) gotb.push_back({b_ochan, b_olast, b_odata});
        end
        expb[0] = {2'd0, 1'b1, 8'hA0};
        expb[1] = {2'd1, 1'b1, 8'hB0};
        expb[2] = {2'd0, 1'b1, 8'hA1};
        expb[3] = {2'd1, 1'b1, 8'hB1};
        chk("nopkt_count", 32'(gotb.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gotb.size()) chk($sformatf("nopkt_beat%0d", i), 32'(gotb[i]), 32'(expb[i]));
        end

        // async reset mid-packet from input 3; pointer must restart at 0
        do_reset();
        ivalid = 4'b0010; ilast = 4'b0010; idata = 32'h0000_5500;
        @(negedge clock);
        @(posedge clock); #1;
        ivalid = 4'b0000;
        @(posedge clock); #1;
        ivalid = 4'b1000; ilast = 4'b0000; idata = 32'h7700_0000;
        repeat (3) @(negedge clock);
        chk("rstmid_busy_pre", 32'(a_busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rstmid_ovalid", 32'(a_ovalid), 32'd0);
        chk("rstmid_busy", 32'(a_busy), 32'd0);
        chk("rstmid_iready", 32'(a_iready), 32'd0);
        ivalid = 4'b1001;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("rstmid_regrant", 32'(a_iready), 32'b0001);

        // randomized traffic against the reference model, both packet modes
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            for (int i = 0; i < NUM; i++) begin
                ivalid[i] = ($urandom_range(0, 9) < 6);
                ilast[i]  = ($urandom_range(0, 2) == 0);
            end
            idata  = $urandom();
            oready = ($urandom_range(0, 9) < 7);
            @(negedge clock);
            model_check(0, a_iready, a_busy, a_ovalid, a_odata, a_ochan, a_olast);
            model_check(1, b_iready, b_busy, b_ovalid, b_odata, b_ochan, b_olast);
            model_step(0);
            model_step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
